bht_controller: RTL and testbench
=================================

BHT_CONTROLLER -- requirements
Module: bht_controller

Interface
REQ-001 Parameter INDEX_BITS, default 4, SHALL set the table size to 2^INDEX_BITS two-bit counters.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the mispredict-statistics counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-high; sampled only on the rising edge of clk.
REQ-005 lookup_valid  input  1  SHALL indicate a fetch-stage prediction request.
REQ-006 lookup_pc  input  16  SHALL carry the fetch PC; index = lookup_pc[INDEX_BITS:1].
REQ-007 update_valid  input  1  SHALL indicate a resolved branch.
REQ-008 update_pc  input  16  SHALL carry the resolved branch PC; index = update_pc[INDEX_BITS:1].
REQ-009 update_taken  input  1  SHALL be the actual branch outcome (1 = taken).
REQ-010 update_predicted  input  1  SHALL be the prediction previously issued for that branch.
REQ-011 ready  output  1  SHALL be high only in state RUN.
REQ-012 pred_valid  output  1  SHALL be high for one cycle per accepted lookup.
REQ-013 pred_taken  output  1  SHALL be the prediction (1 = taken), valid when pred_valid is high.
REQ-014 pred_state  output  2  SHALL be the counter value behind pred_taken.
REQ-015 mispredict_count  output  CNT_WIDTH  SHALL be the running count of mispredicted updates.

Function
REQ-016 Counter encoding SHALL be 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken; prediction = bit 1.
REQ-017 Controller FSM SHALL have states INIT and RUN.
REQ-018 In INIT, one entry per cycle SHALL be written to 01, starting at index 0 and ending at index 2^INDEX_BITS-1.
REQ-019 The transition INIT->RUN SHALL occur on the edge that writes the last entry; INIT lasts exactly 2^INDEX_BITS cycles.
REQ-020 In INIT, lookups and updates SHALL be ignored: no pred_valid, no table change, no count change.
REQ-021 In RUN, lookup_valid SHALL produce pred_valid=1 on the next cycle with pred_taken/pred_state of the indexed entry (latency 1).
REQ-022 With lookup_valid low in RUN, pred_valid SHALL be 0 on the next cycle; pred_taken/pred_state SHALL hold their last values.
REQ-023 An update with update_taken=1 SHALL increment the entry, saturating at 11.
REQ-024 An update with update_taken=0 SHALL decrement the entry, saturating at 00.
REQ-025 An update SHALL be a single-cycle read-modify-write; the entry changes on the edge where update_valid is sampled.
REQ-026 On a simultaneous lookup and update to the same index, the prediction SHALL reflect the post-update value (bypass).
REQ-027 On a simultaneous lookup and update to different indices, both SHALL complete independently in the same cycle.
REQ-028 mispredict_count SHALL increment on a RUN update where update_taken != update_predicted.
REQ-029 mispredict_count SHALL saturate at 2^CNT_WIDTH-1.
REQ-030 PC bit 0 and bits above INDEX_BITS SHALL not affect indexing (aliasing permitted).

Reset
REQ-031 Reset SHALL force INIT, init index 0, ready=0, pred_valid=0, pred_taken=0, pred_state=00, mispredict_count=0.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL restart the full INIT sweep; in-flight lookups are dropped (pred_valid=0 next cycle).
REQ-033 Reset SHALL take priority over any simultaneous lookup or update.

Verification
REQ-034 Reset then idle -> ready=0 for 16 cycles, ready=1 on cycle 17; a lookup of every index returns pred_state=01, pred_taken=0.
REQ-035 After INIT, 3 taken updates to PC 0x0006 -> states 10, 11, 11; lookup returns pred_taken=1, pred_state=11; 4 not-taken updates -> 10, 01, 00, 00.
REQ-036 Same-cycle lookup and update to PC 0x0004 (entry 01, taken) -> next cycle pred_state=10, pred_taken=1.
REQ-037 Updates with (taken, predicted) = (1,0), (0,0), (0,1) -> mispredict_count=2; with CNT_WIDTH=2 and 5 mispredicts -> count holds at 3.
REQ-038 Lookups and updates during INIT -> pred_valid stays 0; table reads 01 after INIT; count stays 0.
REQ-039 Reset pulsed in RUN with modified entries -> ready drops next cycle, a 16-cycle sweep follows, all entries read 01, count=0.

Source files
------------

// File: rtl/bht_controller.sv
// Branch history table of 2-bit saturating counters with an init sweep,
// same-index update bypass and a saturating mispredict counter.
module bht_controller #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lookup_valid,
  input  logic [15:0]          lookup_pc,
  input  logic                 update_valid,
  input  logic [15:0]          update_pc,
  input  logic                 update_taken,
  input  logic                 update_predicted,
  output logic                 ready,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [1:0]           pred_state,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   init_idx_q, init_idx_d;
  logic [1:0]              tbl_q [DEPTH];
  logic [1:0]              tbl_d [DEPTH];
  logic                    pred_valid_q, pred_valid_d;
  logic                    pred_taken_q, pred_taken_d;
  logic [1:0]              pred_state_q, pred_state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic [INDEX_BITS-1:0]   lk_idx;
  logic [INDEX_BITS-1:0]   up_idx;
  logic [1:0]              up_old;
  logic [1:0]              up_new;
  logic [1:0]              lk_val;
  logic                    unused_pc;

  assign lk_idx = lookup_pc[INDEX_BITS:1];
  assign up_idx = update_pc[INDEX_BITS:1];

  // PC bits outside the index field are deliberately ignored (aliasing).
  assign unused_pc = ^{lookup_pc[15:INDEX_BITS+1], lookup_pc[0],
                       update_pc[15:INDEX_BITS+1], update_pc[0]};

  always_comb begin
    up_old = tbl_q[up_idx];
    up_new = up_old;
    if (update_taken) begin
      if (up_old != 2'b11) up_new = up_old + 2'd1;
    end else begin
      if (up_old != 2'b00) up_new = up_old - 2'd1;
    end
  end

  // Same-index bypass: the lookup sees the value being written this edge.
  always_comb begin
    lk_val = tbl_q[lk_idx];
    if (update_valid && (up_idx == lk_idx)) lk_val = up_new;
  end

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    tbl_d        = tbl_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_state_d = pred_state_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      INIT: begin
        tbl_d[init_idx_q] = 2'b01;
        init_idx_d        = init_idx_q + 1'b1;
        if (init_idx_q == INDEX_BITS'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (update_valid) begin
          tbl_d[up_idx] = up_new;
          if ((update_taken != update_predicted) && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
        end
        if (lookup_valid) begin
          pred_valid_d = 1'b1;
          pred_state_d = lk_val;
          pred_taken_d = lk_val[1];
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      init_idx_q   <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_state_q <= 2'b00;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_state_q <= pred_state_d;
      cnt_q        <= cnt_d;
    end
  end

  // Table contents need no reset: every reset is followed by a full sweep.
  always_ff @(posedge clk) begin
    if (!reset) tbl_q <= tbl_d;
  end

  assign ready            = (state_q == RUN);
  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_state       = pred_state_q;
  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_bht_controller.sv
// Bench for bht_controller: vector table, corner sequences and a
// randomized run against a behavioural table model.
module tb_bht_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [15:0] lookup_pc;
  logic        update_valid;
  logic [15:0] update_pc;
  logic        update_taken;
  logic        update_predicted;

  logic        ready, pred_valid, pred_taken;
  logic [1:0]  pred_state;
  logic [15:0] cnt;
  logic        ready2, pred_valid2, pred_taken2;
  logic [1:0]  pred_state2;
  logic [1:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bht_controller #(.INDEX_BITS(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_predicted(update_predicted),
    .ready(ready), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_state(pred_state), .mispredict_count(cnt)
  );

  bht_controller #(.INDEX_BITS(4), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_predicted(update_predicted),
    .ready(ready2), .pred_valid(pred_valid2), .pred_taken(pred_taken2),
    .pred_state(pred_state2), .mispredict_count(cnt2)
  );

  typedef struct {
    logic        uv;
    logic [15:0] upc;
    logic        ut;
    logic        up;
    logic        lv;
    logic [15:0] lpc;
    logic        epv;
    logic [1:0]  est;
    int          ecnt;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid     = 1'b0;
    lookup_pc        = '0;
    update_valid     = 1'b0;
    update_pc        = '0;
    update_taken     = 1'b0;
    update_predicted = 1'b0;
  endtask

  task automatic sweep_ready();
    for (int k = 0; k <= 16; k++) begin
      chk($sformatf("ready_c%0d", k + 1), 32'(ready), 32'(k == 16));
      if (k < 16) step();
    end
  endtask

  task automatic lookup_all_01(input string tag);
    for (int i = 0; i < 16; i++) begin
      lookup_valid = 1'b1;
      lookup_pc    = 16'(i * 2);
      step();
      chk($sformatf("%s_pv%0d", tag, i), 32'(pred_valid), 32'd1);
      chk($sformatf("%s_ps%0d", tag, i), 32'(pred_state), 32'd1);
      chk($sformatf("%s_pt%0d", tag, i), 32'(pred_taken), 32'd0);
    end
    idle();
  endtask

  int m_tbl [16];
  int m_cnt, m_cnt2, m_ps, exp_pv, ui, li;

  initial begin
    vt[0]  = '{1'b1, 16'h0006, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 2'b10, 0};
    vt[1]  = '{1'b1, 16'h0006, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 2'b11, 0};
    vt[2]  = '{1'b1, 16'h0006, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 2'b11, 0};
    vt[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0006, 1'b1, 2'b11, 0};
    vt[4]  = '{1'b1, 16'h0006, 1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 2'b10, 1};
    vt[5]  = '{1'b1, 16'h0006, 1'b0, 1'b0, 1'b1, 16'h0006, 1'b1, 2'b01, 1};
    vt[6]  = '{1'b1, 16'h0006, 1'b0, 1'b0, 1'b1, 16'h0026, 1'b1, 2'b00, 1};
    vt[7]  = '{1'b1, 16'h0006, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 2'b00, 1};
    vt[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b00, 1};
    vt[9]  = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 2'b10, 2};
    vt[10] = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0008, 1'b1, 2'b01, 2};
    vt[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 2'b01, 2};
    vt[12] = '{1'b1, 16'h000A, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 2'b01, 3};
    vt[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 2'b10, 3};

    idle();
    reset = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_pv", 32'(pred_valid), 32'd0);
    chk("rst_pt", 32'(pred_taken), 32'd0);
    chk("rst_ps", 32'(pred_state), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    reset = 1'b0;
    sweep_ready();
    lookup_all_01("post_init");

    for (int i = 0; i < 14; i++) begin
      update_valid     = vt[i].uv;
      update_pc        = vt[i].upc;
      update_taken     = vt[i].ut;
      update_predicted = vt[i].up;
      lookup_valid     = vt[i].lv;
      lookup_pc        = vt[i].lpc;
      step();
      chk($sformatf("vec%0d_pv", i), 32'(pred_valid), 32'(vt[i].epv));
      chk($sformatf("vec%0d_ps", i), 32'(pred_state), 32'(vt[i].est));
      chk($sformatf("vec%0d_pt", i), 32'(pred_taken), 32'(vt[i].est[1]));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vt[i].ecnt));
      chk($sformatf("vec%0d_cnt2", i), 32'(cnt2),
          32'((vt[i].ecnt > 3) ? 3 : vt[i].ecnt));
    end
    idle();

    for (int i = 0; i < 5; i++) begin
      update_valid     = 1'b1;
      update_pc        = 16'h0010;
      update_taken     = i[0];
      update_predicted = ~i[0];
      step();
    end
    idle();
    chk("sat_cnt16", 32'(cnt), 32'd8);
    chk("sat_cnt2", 32'(cnt2), 32'd3);

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      lookup_valid     = 1'b1;
      lookup_pc        = 16'($urandom);
      update_valid     = 1'b1;
      update_pc        = 16'($urandom);
      update_taken     = 1'b1;
      update_predicted = 1'b0;
      step();
      chk($sformatf("init_pv%0d", k), 32'(pred_valid), 32'd0);
      chk($sformatf("init_cnt%0d", k), 32'(cnt), 32'd0);
    end
    idle();
    chk("init_ready", 32'(ready), 32'd1);
    lookup_all_01("init_ign");
    chk("init_ign_cnt", 32'(cnt), 32'd0);

    for (int i = 0; i < 4; i++) begin
      update_valid     = 1'b1;
      update_pc        = 16'(2 + 2 * (i % 2));
      update_taken     = 1'b1;
      update_predicted = 1'b0;
      step();
    end
    reset            = 1'b1;
    lookup_valid     = 1'b1;
    lookup_pc        = 16'h0002;
    step();
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_pv", 32'(pred_valid), 32'd0);
    chk("mid_rst_ps", 32'(pred_state), 32'd0);
    chk("mid_rst_cnt", 32'(cnt), 32'd0);
    reset = 1'b0;
    idle();
    sweep_ready();
    lookup_all_01("mid_rst");
    chk("mid_rst_cnt_after", 32'(cnt), 32'd0);

    foreach (m_tbl[i]) m_tbl[i] = 1;
    m_cnt  = 0;
    m_cnt2 = 0;
    m_ps   = 1;
    for (int c = 0; c < 400; c++) begin
      update_valid     = 1'($urandom_range(0, 1));
      update_pc        = 16'($urandom_range(0, 127));
      update_taken     = 1'($urandom_range(0, 1));
      update_predicted = 1'($urandom_range(0, 1));
      lookup_valid     = 1'($urandom_range(0, 1));
      lookup_pc        = ($urandom_range(0, 3) == 0) ? update_pc
                                                     : 16'($urandom);
      if (update_valid) begin
        ui = (int'(update_pc) / 2) % 16;
        if (update_taken) m_tbl[ui] = (m_tbl[ui] == 3) ? 3 : m_tbl[ui] + 1;
        else              m_tbl[ui] = (m_tbl[ui] == 0) ? 0 : m_tbl[ui] - 1;
        if (update_taken != update_predicted) begin
          m_cnt  = m_cnt + 1;
          m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
        end
      end
      exp_pv = int'(lookup_valid);
      if (lookup_valid) begin
        li   = (int'(lookup_pc) / 2) % 16;
        m_ps = m_tbl[li];
      end
      step();
      chk($sformatf("rnd%0d_pv", c), 32'(pred_valid), 32'(exp_pv));
      chk($sformatf("rnd%0d_ps", c), 32'(pred_state), 32'(m_ps));
      chk($sformatf("rnd%0d_pt", c), 32'(pred_taken), 32'(m_ps / 2));
      chk($sformatf("rnd%0d_cnt", c), 32'(cnt), 32'(m_cnt));
      chk($sformatf("rnd%0d_cnt2", c), 32'(cnt2), 32'(m_cnt2));
      chk($sformatf("rnd%0d_ps2", c), 32'(pred_state2), 32'(m_ps));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
